cs2fifod: RTL and testbench

//  Reply/status packer: the transmit-direction counterpart of the command parser that reads fifoc.
//  On an fs request from cs, it snapshots device status and ADC register values. It then writes
//  one framed reply, byte by byte, into the write port of fifod (sys_clk domain) for later UDP

---
 rtl/cs2fifod.sv | 170 +++++++++++++++++
 tb/tb_cs2fifod.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cs2fifod.sv
// cs2fifod: snapshots device status and ADC registers on an fs request and writes one framed reply
// (HDR0, HDR1, kind, smpr, regs[, checksum]) into the fifod write port. Build macro: CS2FIFOD_CHKSUM_EN.
module cs2fifod #(
  parameter int         NREG = 14,
  parameter logic [7:0] HDR0 = 8'h55,
  parameter logic [7:0] HDR1 = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [7:0]        dev_kind,
  input  logic [7:0]        dev_smpr,
  input  logic [8*NREG-1:0] adc_regs,
  input  logic              fifod_full,
  output logic              fifod_txen,
  output logic [7:0]        fifod_txd,
  output logic [11:0]       tx_len
);

`ifdef CS2FIFOD_CHKSUM_EN
  localparam int LEN = 5 + NREG;
`else
  localparam int LEN = 4 + NREG;
`endif
  localparam logic [8:0]  LAST_IDX = 9'(LEN - 1);
  localparam logic [8:0]  REG_END  = 9'(4 + NREG);
  localparam logic [11:0] LEN_W    = 12'(LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              fd_q, fd_d;
  logic              txen_q, txen_d;
  logic [7:0]        txd_q, txd_d;
  logic [8:0]        idx_q, idx_d;
  logic [11:0]       tx_len_q;
  logic [7:0]        kind_q, kind_d;
  logic [7:0]        smpr_q, smpr_d;
  logic [8*NREG-1:0] regs_q, regs_d;
  logic [8:0]        reg_off;
  logic [7:0]        reg_byte;
  logic [7:0]        cur_byte;
`ifdef CS2FIFOD_CHKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return 8'(acc + b);
  endfunction

  // Select the snapshot byte addressed by idx.
  always_comb begin
    reg_off  = idx_q - 9'd4;
    reg_byte = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      reg_byte = reg_byte | ((reg_off == 9'(i)) ? regs_q[8*i +: 8] : 8'h00);
    end
    if (idx_q == 9'd0)        cur_byte = HDR0;
    else if (idx_q == 9'd1)   cur_byte = HDR1;
    else if (idx_q == 9'd2)   cur_byte = kind_q;
    else if (idx_q == 9'd3)   cur_byte = smpr_q;
    else if (idx_q < REG_END) cur_byte = reg_byte;
`ifdef CS2FIFOD_CHKSUM_EN
    else                      cur_byte = sum_q;
`else
    else                      cur_byte = 8'h00;
`endif
  end

  // Next-state and registered-output logic for the packer FSM.
  always_comb begin
    state_d = state_q;
    fd_d    = fd_q;
    txen_d  = 1'b0;
    txd_d   = txd_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    smpr_d  = smpr_q;
    regs_d  = regs_q;
`ifdef CS2FIFOD_CHKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        fd_d = 1'b0;
        if (fs) state_d = LOAD;
        else    state_d = IDLE;
      end
      LOAD: begin
        kind_d  = dev_kind;
        smpr_d  = dev_smpr;
        regs_d  = adc_regs;
        idx_d   = 9'd0;
`ifdef CS2FIFOD_CHKSUM_EN
        sum_d   = 8'h00;
`endif
        state_d = SEND;
      end
      SEND: begin
        if (!fifod_full) begin
          txen_d = 1'b1;
          txd_d  = cur_byte;
          idx_d  = idx_q + 9'd1;
`ifdef CS2FIFOD_CHKSUM_EN
          if ((idx_q >= 9'd2) && (idx_q < REG_END)) sum_d = sum8(sum_q, cur_byte);
          else                                      sum_d = sum_q;
`endif
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   state_d = SEND;
        end else begin
          txen_d = 1'b0;
        end
      end
      DONE: begin
        // fd is raised for at least one cycle even if fs was only a short pulse.
        fd_d   = fs | ~fd_q;
        txen_d = 1'b0;
        if (fs) state_d = DONE;
        else    state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        fd_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fd_q     <= 1'b0;
      txen_q   <= 1'b0;
      txd_q    <= 8'h00;
      idx_q    <= 9'd0;
      tx_len_q <= LEN_W;
      kind_q   <= 8'h00;
      smpr_q   <= 8'h00;
      regs_q   <= {(8*NREG){1'b0}};
`ifdef CS2FIFOD_CHKSUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      fd_q     <= fd_d;
      txen_q   <= txen_d;
      txd_q    <= txd_d;
      idx_q    <= idx_d;
      tx_len_q <= LEN_W;
      kind_q   <= kind_d;
      smpr_q   <= smpr_d;
      regs_q   <= regs_d;
`ifdef CS2FIFOD_CHKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign fd         = fd_q;
  assign fifod_txen = txen_q;
  assign fifod_txd  = txd_q;
  assign tx_len     = tx_len_q;

endmodule

// File: tb/tb_cs2fifod.sv
// Directed self-checking bench for cs2fifod: nominal frame, backpressure, snapshot, handshake, reset abort.
module tb_cs2fifod;
  localparam int NREG = 14;
`ifdef CS2FIFOD_CHKSUM_EN
  localparam int LEN = 5 + NREG;
`else
  localparam int LEN = 4 + NREG;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              fs;
  logic              fd;
  logic [7:0]        dev_kind;
  logic [7:0]        dev_smpr;
  logic [8*NREG-1:0] adc_regs;
  logic              fifod_full;
  logic              fifod_txen;
  logic [7:0]        fifod_txd;
  logic [11:0]       tx_len;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_bytes [LEN];

  cs2fifod #(.NREG(NREG), .HDR0(8'h55), .HDR1(8'hAA)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd),
    .dev_kind(dev_kind), .dev_smpr(dev_smpr), .adc_regs(adc_regs),
    .fifod_full(fifod_full), .fifod_txen(fifod_txen), .fifod_txd(fifod_txd),
    .tx_len(tx_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: fs raised at edge 0, optional stall before byte stall_idx, optional snapshot disturbance.
  task automatic frame(input string tag, input int stall_idx, input int stall_n,
                       input bit keep_fs, input bit poke_kind);
    fs = 1'b1;
    tick();
    if (!keep_fs) fs = 1'b0;
    tick();
    chk({tag, ":lead_txen"}, {11'd0, fifod_txen}, 12'd0);
    if (poke_kind) dev_kind = 8'hFF;
    for (int k = 0; k < LEN; k++) begin
      if (k == stall_idx) begin
        fifod_full = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk({tag, ":stall_txen"}, {11'd0, fifod_txen}, 12'd0);
        end
        fifod_full = 1'b0;
      end
      tick();
      chk($sformatf("%s:txen%0d", tag, k), {11'd0, fifod_txen}, 12'd1);
      chk($sformatf("%s:byte%0d", tag, k), {4'd0, fifod_txd}, {4'd0, exp_bytes[k]});
    end
    chk({tag, ":fd_early"}, {11'd0, fd}, 12'd0);
    tick();
    chk({tag, ":fd"}, {11'd0, fd}, 12'd1);
    chk({tag, ":post_txen"}, {11'd0, fifod_txen}, 12'd0);
    if (poke_kind) dev_kind = 8'h01;
  endtask

  initial begin
    logic [7:0] sum;
    rst        = 1'b1;
    fs         = 1'b0;
    fifod_full = 1'b0;
    dev_kind   = 8'h01;
    dev_smpr   = 8'h02;
    for (int i = 0; i < NREG; i++) adc_regs[8*i +: 8] = 8'(8'h10 + i);

    exp_bytes[0] = 8'h55;
    exp_bytes[1] = 8'hAA;
    exp_bytes[2] = 8'h01;
    exp_bytes[3] = 8'h02;
    sum = 8'h03;
    for (int i = 0; i < NREG; i++) begin
      exp_bytes[4+i] = 8'(8'h10 + i);
      sum = 8'(sum + 8'h10 + i);
    end
`ifdef CS2FIFOD_CHKSUM_EN
    exp_bytes[LEN-1] = sum;
`endif

    // Reset state
    #2;
    chk("rst_fd", {11'd0, fd}, 12'd0);
    chk("rst_txen", {11'd0, fifod_txen}, 12'd0);
    chk("rst_txd", {4'd0, fifod_txd}, 12'h000);
    chk("rst_tx_len", tx_len, 12'(LEN));
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_fd", {11'd0, fd}, 12'd0);

    // Test 1/2: nominal frame with fs pulse
    frame("nominal", -1, 0, 1'b0, 1'b0);
    chk("nominal_tx_len", tx_len, 12'(LEN));
    tick();
    chk("nominal_fd_fall", {11'd0, fd}, 12'd0);
    tick();

    // Test 3: 3-cycle stall at idx 5
    frame("stall", 5, 3, 1'b0, 1'b0);
    tick();
    tick();

    // Test 4: dev_kind changes after the snapshot
    frame("snapshot", -1, 0, 1'b0, 1'b1);
    tick();
    tick();

    // Test 5: fs held past fd, then released and re-raised
    frame("hold", -1, 0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_fd", {11'd0, fd}, 12'd1);
      chk("hold_txen", {11'd0, fifod_txen}, 12'd0);
    end
    fs = 1'b0;
    tick();
    chk("hold_fd_drop", {11'd0, fd}, 12'd0);
    frame("second", -1, 0, 1'b0, 1'b0);
    tick();
    tick();

    // Test 6: reset with idx at 7
    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) tick();
    chk("pre_abort_txd", {4'd0, fifod_txd}, {4'd0, exp_bytes[6]});
    #2;
    rst = 1'b1;
    #1;
    chk("abort_txen", {11'd0, fifod_txen}, 12'd0);
    chk("abort_fd", {11'd0, fd}, 12'd0);
    chk("abort_txd", {4'd0, fifod_txd}, 12'h000);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_txen", {11'd0, fifod_txen}, 12'd0);
    frame("post_rst", -1, 0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
